// File: rtl/frame_config_pkg.sv
// Shared types and constants for the frame configuration writer: FSM states,
// header sync byte, header field positions and the header validity check.
package frame_config_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_STROBE = 2'd3
    } state_e;

    localparam logic [7:0] FRAME_SYNC   = 8'hFA;
    localparam int         HDR_SYNC_LSB = 24;
    localparam int         HDR_COL_LSB  = 16;
    localparam int         HDR_CNT_LSB  = 0;
    localparam int         HDR_FIELD_W  = 8;

    // A header is usable only when sync matches and column/count are in range.
    function automatic logic hdr_ok(input logic [31:0] word,
                                    input int unsigned num_cols,
                                    input int unsigned max_frames);
        logic [31:0] col;
        logic [31:0] cnt;
        col = {24'd0, word[HDR_COL_LSB +: HDR_FIELD_W]};
        cnt = {24'd0, word[HDR_CNT_LSB +: HDR_FIELD_W]};
        return (word[HDR_SYNC_LSB +: HDR_FIELD_W] == FRAME_SYNC) &&
               (col < num_cols) && (cnt >= 32'd1) && (cnt <= max_frames);
    endfunction

endpackage

// File: rtl/frame_config_writer_strobe.sv
// Combinational one-hot decoder from (column, frame) to the frame latch strobe
// vector; the caller registers the result.
module frame_strobe_decoder
    import frame_config_pkg::*;
#(
    parameter int NumberOfCols    = 8,
    parameter int MaxFramesPerCol = 20,
    parameter int ColW            = 3,
    parameter int FrameW          = 5
) (
    input  logic [ColW-1:0]                        col,
    input  logic [FrameW-1:0]                      frame,
    input  logic                                   en,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

    int idx;

    // Full-width strobe index; header checking keeps it inside the vector.
    always_comb begin
        strobe = '0;
        idx    = int'(col) * MaxFramesPerCol + int'(frame);
        for (int i = 0; i < NumberOfCols * MaxFramesPerCol; i++) begin
            strobe[i] = en && (idx == i);
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Assembles per-column frame packets from a 32-bit word stream into FrameData
// and pulses the addressed FrameStrobe bit. Optional feature: FRAME_CHECKSUM_EN.
module frame_config_writer
    import frame_config_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 4,
    parameter int NumberOfCols    = 8,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                        CLK,
    input  logic                                        RST,
    input  logic [31:0]                                 s_data,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]     FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]     FrameStrobe,
    output logic                                        col_done,
    output logic                                        err_hdr,
    output logic                                        err_sum
);

    localparam int ColW    = (NumberOfCols > 1) ? $clog2(NumberOfCols) : 1;
    localparam int FrameW  = $clog2(MaxFramesPerCol + 1);
    localparam int RowW    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int DataW   = FrameBitsPerRow * NumberOfRows;
    localparam int StrobeW = NumberOfCols * MaxFramesPerCol;

    state_e               state_q, state_d;
    logic [ColW-1:0]      col_q, col_d;
    logic [FrameW-1:0]    n_q, n_d;
    logic [FrameW-1:0]    frame_q, frame_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [DataW-1:0]     frame_data_q, frame_data_d;
    logic [StrobeW-1:0]   strobe_q, strobe_d;
    logic                 s_ready_q, s_ready_d;
    logic                 col_done_q, col_done_d;
    logic                 err_hdr_q, err_hdr_d;
    logic                 strobe_en_s;
    logic                 accept_s;
`ifdef FRAME_CHECKSUM_EN
    logic [31:0]          sum_q, sum_d;
    logic                 err_sum_q, err_sum_d;
`endif

    assign accept_s    = s_valid & s_ready_q;
    assign s_ready     = s_ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign col_done    = col_done_q;
    assign err_hdr     = err_hdr_q;
`ifdef FRAME_CHECKSUM_EN
    assign err_sum     = err_sum_q;
`else
    assign err_sum     = 1'b0;
`endif

    frame_strobe_decoder #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol),
        .ColW            (ColW),
        .FrameW          (FrameW)
    ) u_strobe_dec (
        .col    (col_q),
        .frame  (frame_q),
        .en     (strobe_en_s),
        .strobe (strobe_d)
    );

    // Next-state and datapath logic; the strobe is requested on the cycle the
    // last frame (or checksum) word is accepted so it appears one cycle later.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        n_d          = n_q;
        frame_d      = frame_q;
        row_d        = row_q;
        frame_data_d = frame_data_q;
        col_done_d   = 1'b0;
        err_hdr_d    = err_hdr_q;
        strobe_en_s  = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        sum_d        = sum_q;
        err_sum_d    = err_sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (hdr_ok(s_data, NumberOfCols, MaxFramesPerCol)) begin
                        col_d   = s_data[HDR_COL_LSB +: ColW];
                        n_d     = s_data[HDR_CNT_LSB +: FrameW];
                        frame_d = '0;
                        row_d   = '0;
`ifdef FRAME_CHECKSUM_EN
                        sum_d   = 32'd0;
`endif
                        state_d = ST_LOAD;
                    end else begin
                        err_hdr_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    for (int r = 0; r < NumberOfRows; r++) begin
                        frame_data_d[FrameBitsPerRow*r +: FrameBitsPerRow] =
                            (row_q == RowW'(r)) ? s_data
                                                : frame_data_q[FrameBitsPerRow*r +: FrameBitsPerRow];
                    end
`ifdef FRAME_CHECKSUM_EN
                    sum_d = sum_q ^ s_data;
`endif
                    if (row_q == RowW'(NumberOfRows - 1)) begin
                        row_d = '0;
`ifdef FRAME_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d     = ST_STROBE;
                        strobe_en_s = 1'b1;
`endif
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    if (s_data == sum_q) begin
                        state_d     = ST_STROBE;
                        strobe_en_s = 1'b1;
                    end else begin
                        // Mismatch abandons the remainder of the packet.
                        err_sum_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_STROBE: begin
                frame_d = frame_q + FrameW'(1);
                if ((frame_q + FrameW'(1)) == n_q) begin
                    col_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
`ifdef FRAME_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d != ST_STROBE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            n_q          <= '0;
            frame_q      <= '0;
            row_q        <= '0;
            frame_data_q <= '0;
            strobe_q     <= '0;
            s_ready_q    <= 1'b0;
            col_done_q   <= 1'b0;
            err_hdr_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum_q        <= 32'd0;
            err_sum_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            n_q          <= n_d;
            frame_q      <= frame_d;
            row_q        <= row_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            s_ready_q    <= s_ready_d;
            col_done_q   <= col_done_d;
            err_hdr_q    <= err_hdr_d;
`ifdef FRAME_CHECKSUM_EN
            sum_q        <= sum_d;
            err_sum_q    <= err_sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_config_writer.sv
// Randomized bench for frame_config_writer: packets are generated here and the
// expected strobe/data/done/ready/error behaviour is derived per cycle from them.
module tb_frame_config_writer;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int MAXF = 20;
    localparam int BIG  = 32'h7fff_ffff;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [31:0]  s_data = 32'd0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] FrameData;
    logic [159:0] FrameStrobe;
    logic         col_done;
    logic         err_hdr;
    logic         err_sum;

    frame_config_writer #(
        .FrameBitsPerRow (32),
        .NumberOfRows    (ROWS),
        .NumberOfCols    (COLS),
        .MaxFramesPerCol (MAXF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .col_done    (col_done),
        .err_hdr     (err_hdr),
        .err_sum     (err_sum)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expectations keyed by cycle number.
    int           exp_strobe[int];
    logic [127:0] exp_data[int];
    bit           exp_done[int];
    int           err_hdr_from = BIG;
    int           err_sum_from = BIG;
    bit           started  = 1'b0;
    bit           rst_prev = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the expectation tables.
    always @(negedge CLK) begin
        if (started) begin
            if (rst_prev) begin
                chk("rst_ready",  160'(s_ready),     160'd0);
                chk("rst_data",   160'(FrameData),   160'd0);
                chk("rst_strobe", FrameStrobe,       160'd0);
                chk("rst_done",   160'(col_done),    160'd0);
                chk("rst_errhdr", 160'(err_hdr),     160'd0);
                chk("rst_errsum", 160'(err_sum),     160'd0);
            end else begin
                if (exp_strobe.exists(cyc)) begin
                    chk("strobe", FrameStrobe, 160'd1 << exp_strobe[cyc]);
                    chk("data", 160'(FrameData), 160'(exp_data[cyc]));
                    chk("ready_strobe", 160'(s_ready), 160'd0);
                end else begin
                    chk("strobe_idle", FrameStrobe, 160'd0);
                    chk("ready", 160'(s_ready), 160'd1);
                end
                chk("col_done", 160'(col_done), 160'(exp_done.exists(cyc)));
                chk("err_hdr", 160'(err_hdr), 160'(cyc >= err_hdr_from));
                chk("err_sum", 160'(err_sum), 160'(cyc >= err_sum_from));
            end
        end
        started  <= started | RST;
        rst_prev <= RST;
    end

    task automatic send_word(input logic [31:0] w, input int gapmode, output int acc);
        int gap;
        bit got;
        gap = (gapmode == 1) ? 1 :
              (gapmode == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge CLK); #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        got     = 1'b0;
        acc     = cyc;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            if (s_ready === 1'b1) begin
                acc = cyc;
                got = 1'b1;
            end
            @(posedge CLK); #1;
        end
        s_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout word=%h s_ready=%b", w, s_ready);
        end
    endtask

    task automatic send_packet(input logic [7:0] sync, input logic [7:0] col, input logic [7:0] n,
                               input int gapmode, input bit seq, input bit bad_sum);
        int           acc;
        logic [127:0] fd;
        logic [31:0]  w;
        logic [31:0]  sum;
        send_word({sync, col, 8'($urandom), n}, gapmode, acc);
        if (!(sync == 8'hFA && col < COLS && n >= 1 && n <= MAXF)) begin
            if (err_hdr_from == BIG) err_hdr_from = acc + 1;
            return;
        end
        for (int f = 0; f < int'(n); f++) begin
            sum = 32'd0;
            fd  = '0;
            for (int k = 0; k < ROWS; k++) begin
                w = seq ? 32'(f * ROWS + k + 1) : $urandom;
                fd[32*k +: 32] = w;
                sum = sum ^ w;
                send_word(w, gapmode, acc);
            end
`ifdef FRAME_CHECKSUM_EN
            send_word(bad_sum ? (sum ^ 32'd1) : sum, gapmode, acc);
            if (bad_sum) begin
                if (err_sum_from == BIG) err_sum_from = acc + 1;
                return;
            end
`endif
            exp_strobe[acc + 1] = int'(col) * MAXF + f;
            exp_data[acc + 1]   = fd;
            if (f == int'(n) - 1) exp_done[acc + 2] = 1'b1;
        end
        if (bad_sum && sum == 32'hFFFF_FFFF) $display("note: all-ones checksum");
    endtask

    task automatic do_reset();
        RST = 1'b1;
        s_valid = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        err_hdr_from = BIG;
        err_sum_from = BIG;
        RST = 1'b0;
    endtask

    initial begin
        int acc;
        int kind;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
        end

        // Single-frame packet with hand-checked results.
        send_packet(8'hFA, 8'd3, 8'd1, 0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t1_strobe60", 160'(FrameStrobe[60]), 160'd1);
        chk("t1_data", 160'(FrameData), 160'({32'd4, 32'd3, 32'd2, 32'd1}));
        @(negedge CLK);
        chk("t1_done", 160'(col_done), 160'd1);
        @(posedge CLK); #1;

        // Full column, back to back.
        send_packet(8'hFA, 8'd7, 8'd20, 0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("t2_last159", 160'(FrameStrobe[159]), 160'd1);
        @(posedge CLK); #1;

        // Bad headers, then a good packet.
        send_packet(8'hFB, 8'd0, 8'd1, 0, 1'b1, 1'b0);
        send_packet(8'hFA, 8'd8, 8'd1, 0, 1'b1, 1'b0);
        send_packet(8'hFA, 8'd2, 8'd0, 0, 1'b1, 1'b0);
        send_packet(8'hFA, 8'd2, 8'd21, 0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t3_err_hdr", 160'(err_hdr), 160'd1);
        @(posedge CLK); #1;
        send_packet(8'hFA, 8'd1, 8'd2, 2, 1'b0, 1'b0);

        // Valid toggling every other cycle.
        send_packet(8'hFA, 8'd3, 8'd2, 1, 1'b1, 1'b0);

        // Reset in the middle of a frame.
        send_word(32'hFA02_0001, 0, acc);
        for (int k = 0; k < 3; k++) send_word(32'(k + 1), 0, acc);
        do_reset();
        repeat (2) begin
            @(posedge CLK); #1;
        end
        send_packet(8'hFA, 8'd2, 8'd1, 0, 1'b1, 1'b0);

`ifdef FRAME_CHECKSUM_EN
        send_packet(8'hFA, 8'd0, 8'd1, 0, 1'b1, 1'b0);
        send_packet(8'hFA, 8'd0, 8'd1, 0, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t6_err_sum", 160'(err_sum), 160'd1);
        @(posedge CLK); #1;
        send_packet(8'hFA, 8'd5, 8'd2, 0, 1'b0, 1'b0);
`endif

        // Random mix of packets and occasional bad headers.
        for (int p = 0; p < 30; p++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: send_packet(8'hFA, 8'($urandom_range(8, 255)), 8'd1, 2, 1'b0, 1'b0);
                1: send_packet(8'hFA, 8'($urandom_range(0, 7)), 8'($urandom_range(21, 255)), 2, 1'b0, 1'b0);
                default: send_packet(8'hFA, 8'($urandom_range(0, 7)), 8'($urandom_range(1, 3)), 2, 1'b0, 1'b0);
            endcase
        end

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
